// File: rtl/gpio_in_filter.sv
// gpio_in_filter: pad resync, per-pin debounce, edge detect, sticky irq.
// Define GPIO_IN_FILTER_IRQ_EN to build pending flags and irq_o.
module gpio_in_filter #(
    parameter int GPIO_NUM        = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [GPIO_NUM-1:0] pad_i,
    input  logic [GPIO_NUM-1:0] dir_i,
    input  logic [GPIO_NUM-1:0] rise_en_i,
    input  logic [GPIO_NUM-1:0] fall_en_i,
    input  logic [GPIO_NUM-1:0] irq_clr_i,
    output logic [GPIO_NUM-1:0] pin_o,
    output logic [GPIO_NUM-1:0] rise_o,
    output logic [GPIO_NUM-1:0] fall_o,
    output logic [GPIO_NUM-1:0] pending_o,
    output logic                irq_o
);

    // A zero setting behaves like a single-cycle debounce.
    localparam int         DB       = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam logic [7:0] CNT_LAST = 8'(DB - 1);

    logic [GPIO_NUM-1:0]      sync1_q;
    logic [GPIO_NUM-1:0]      sync2_q;
    logic [GPIO_NUM-1:0][7:0] cnt_q;
    logic [GPIO_NUM-1:0][7:0] cnt_d;
    logic [GPIO_NUM-1:0]      pin_q;
    logic [GPIO_NUM-1:0]      pin_d;
    logic [GPIO_NUM-1:0]      rise_q;
    logic [GPIO_NUM-1:0]      rise_d;
    logic [GPIO_NUM-1:0]      fall_q;
    logic [GPIO_NUM-1:0]      fall_d;

    // Two-flop resynchroniser for the asynchronous pads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
        end
    end

    // Per-pin debounce; output pins just read back the synced level.
    always_comb begin
        pin_d  = pin_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < GPIO_NUM; i++) begin
            if (dir_i[i]) begin
                pin_d[i] = sync2_q[i];
                cnt_d[i] = 8'd0;
            end else if (sync2_q[i] == pin_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == CNT_LAST) begin
                pin_d[i]  = sync2_q[i];
                cnt_d[i]  = 8'd0;
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // Stable level, counters and registered edge pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            pin_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pin_q  <= pin_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign pin_o  = pin_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef GPIO_IN_FILTER_IRQ_EN
    logic [GPIO_NUM-1:0] pend_q;
    logic [GPIO_NUM-1:0] pend_d;

    // A new enabled edge beats a clear arriving in the same cycle.
    always_comb begin
        pend_d = (pend_q & ~irq_clr_i)
               | (rise_q & rise_en_i)
               | (fall_q & fall_en_i);
    end

    // Sticky pending flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;
    assign irq_o     = |pend_q;
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{rise_en_i, fall_en_i, irq_clr_i};
    assign pending_o         = '0;
    assign irq_o             = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: directed scoreboard bench for gpio_in_filter.
// Runs with DEBOUNCE_CYCLES=4, GPIO_NUM=8.
module tb_gpio_in_filter;

`ifdef GPIO_IN_FILTER_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] pad    = '0;
    logic [7:0] dir    = '0;
    logic [7:0] ren    = '0;
    logic [7:0] fen    = '0;
    logic [7:0] clr    = '0;
    logic [7:0] pin_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic [7:0] pending_o;
    logic       irq_o;

    gpio_in_filter #(
        .GPIO_NUM        (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pad_i     (pad),
        .dir_i     (dir),
        .rise_en_i (ren),
        .fall_en_i (fen),
        .irq_clr_i (clr),
        .pin_o     (pin_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .pending_o (pending_o),
        .irq_o     (irq_o)
    );

    typedef struct {
        string      tag;
        int         cyc;
        logic [7:0] m;
        logic [7:0] pin;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] pend;
        logic       ci;
        logic       irq;
    } exp_t;

    exp_t        q[$];
    exp_t        ce;
    logic [32:0] got;
    logic [32:0] want;
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_at(
        string tag, int c, logic [7:0] m,
        logic [7:0] pin, logic [7:0] rise, logic [7:0] fall,
        logic [7:0] pend, logic ci, logic irq
    );
        exp_t e;
        e.tag  = tag;
        e.cyc  = c;
        e.m    = m;
        e.pin  = pin;
        e.rise = rise;
        e.fall = fall;
        e.pend = IRQ ? pend : 8'h00;
        e.ci   = ci;
        e.irq  = IRQ ? irq : 1'b0;
        q.push_back(e);
    endfunction

    task automatic at(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(string tag);
        n_chk++;
        assert ({pin_o, rise_o, fall_o, pending_o, irq_o} === 33'd0)
        else begin
            n_fail++;
            $error("FAIL %s got=%h want=0", tag,
                   {pin_o, rise_o, fall_o, pending_o, irq_o});
        end
    endtask

    // Pop and compare every expectation due in this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            ce   = q.pop_front();
            got  = {pin_o & ce.m, rise_o & ce.m, fall_o & ce.m,
                    pending_o & ce.m, irq_o & ce.ci};
            want = {ce.pin & ce.m, ce.rise & ce.m, ce.fall & ce.m,
                    ce.pend & ce.m, ce.irq & ce.ci};
            n_chk++;
            assert (got === want && ce.cyc == cyc)
            else begin
                n_fail++;
                $error("FAIL %s cyc=%0d got=%h want=%h",
                       ce.tag, cyc, got, want);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        at(1);
        chk_zero("reset");
        resetn = 1'b1;

        // Clean rise on pin 0, then clear its flag.
        ren = 8'h05;
        fen = 8'h04;
        exp_at("rise0_pre",  14, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        exp_at("rise0",      15, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
        exp_at("rise0_pend", 16, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1);
        exp_at("rise0_hold", 17, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1);
        exp_at("rise0_clr",  18, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        at(9);
        pad[0] = 1'b1;
        at(17);
        clr[0] = 1'b1;
        at(18);
        clr[0] = 1'b0;

        // Three-sample glitch on pin 1.
        exp_at("glitch_a", 24, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("glitch_b", 25, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("glitch_c", 28, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        at(19);
        pad[1] = 1'b1;
        at(22);
        pad[1] = 1'b0;

        // Pin 2: pending, then clear colliding with a new fall.
        exp_at("p2_rise",  35, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("p2_pend",  36, 8'h04, 8'h04, 8'h00, 8'h00, 8'h04, 1'b1, 1'b1);
        exp_at("p2_fall",  45, 8'h04, 8'h00, 8'h00, 8'h04, 8'h04, 1'b1, 1'b1);
        exp_at("p2_coll",  46, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 1'b1, 1'b1);
        exp_at("p2_clr",   50, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        at(29);
        pad[2] = 1'b1;
        at(39);
        pad[2] = 1'b0;
        at(45);
        clr[2] = 1'b1;
        at(46);
        clr[2] = 1'b0;
        at(49);
        clr[2] = 1'b1;
        at(50);
        clr[2] = 1'b0;

        // Pin 3 as output: read-back with lag, no pulses.
        exp_at("out3_58", 58, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("out3_59", 59, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("out3_61", 61, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("out3_63", 63, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("out3_65", 65, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("out3_67", 67, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("dir3_71", 71, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("dir3_72", 72, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("dir3_74", 74, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("dir3_78", 78, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        at(55);
        dir[3] = 1'b1;
        at(56);
        pad[3] = 1'b1;
        at(58);
        pad[3] = 1'b0;
        at(60);
        pad[3] = 1'b1;
        at(62);
        pad[3] = 1'b0;
        at(64);
        pad[3] = 1'b1;
        at(70);
        dir[3] = 1'b0;

        // Pins 4 and 5 rise together.
        exp_at("p45_rise", 86, 8'h30, 8'h30, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("p45_pend", 87, 8'hFF, 8'h39, 8'h00, 8'h00, 8'h30, 1'b1, 1'b1);
        at(79);
        ren = 8'h30;
        fen = 8'h00;
        at(80);
        pad[5:4] = 2'b11;

        // Reset in the middle of a pin 6 count.
        exp_at("pre_rst",  93, 8'hFF, 8'h39, 8'h00, 8'h00, 8'h30, 1'b1, 1'b1);
        exp_at("post_rst", 95, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        exp_at("p6_early", 99, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        exp_at("p6_rise", 100, 8'hFF, 8'h79, 8'h79, 8'h00, 8'h00, 1'b1, 1'b0);
        exp_at("p6_pend", 101, 8'hFF, 8'h79, 8'h00, 8'h00, 8'h30, 1'b1, 1'b1);
        at(89);
        pad[6] = 1'b1;
        at(93);
        #5;
        resetn = 1'b0;
        #1;
        chk_zero("reset_mid");
        at(94);
        resetn = 1'b1;

        at(105);
        n_chk++;
        assert (q.size() == 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_drain got=%0d want=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in_filter.md
# gpio_in_filter

Input conditioning stage between the GPIO pads and `wb_gpio`. Each pin is resynchronised to `clk`, debounced with a per-pin counter, and edge-detected. The filtered levels feed the GPIO value register in place of raw pad reads, and per-pin edge events set sticky pending flags that drive a single interrupt line.

## Interface
Parameters:
- `GPIO_NUM`, 8: number of pins, 1..32.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed to accept a new level, 1..255. A value of 0 is treated as 1.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, asynchronous, active-low
- `pad_i`  in  GPIO_NUM  raw pad levels, asynchronous to `clk`
- `dir_i`  in  GPIO_NUM  pin direction from the GPIO control register; 1 = output, 0 = input
- `rise_en_i`  in  GPIO_NUM  per-pin enable: rising edge sets pending
- `fall_en_i`  in  GPIO_NUM  per-pin enable: falling edge sets pending
- `irq_clr_i`  in  GPIO_NUM  per-pin pending clear, one-cycle pulse
- `pin_o`  out  GPIO_NUM  filtered level
- `rise_o`  out  GPIO_NUM  one-cycle pulse on an accepted 0→1 transition
- `fall_o`  out  GPIO_NUM  one-cycle pulse on an accepted 1→0 transition
- `pending_o`  out  GPIO_NUM  sticky edge flags
- `irq_o`  out  1  OR of `pending_o`

## Operation
- **Synchroniser:** two flops per pin, reset 0. The output of the second stage is `sync[i]`.
- **Debounce, input pins (`dir_i[i]=0`):**
  - Each pin has an 8-bit counter `cnt[i]` and a stable level `pin_o[i]`.
  - `sync[i]==pin_o[i]`: `cnt[i]` <= 0.
  - `sync[i]!=pin_o[i]` and `cnt[i]==DEBOUNCE_CYCLES-1`: `pin_o[i]` <= `sync[i]`, `cnt[i]` <= 0, and the matching `rise_o[i]` or `fall_o[i]` is asserted for one cycle.
  - Otherwise `cnt[i]` increments.
  - Any glitch shorter than `DEBOUNCE_CYCLES` sync samples restarts the count. No edge is generated for it.
- **Output pins (`dir_i[i]=1`):**
  - `pin_o[i]` <= `sync[i]` every cycle. This is read-back of the driven value.
  - `cnt[i]` is held at 0.
  - `rise_o[i]` and `fall_o[i]` stay 0.
- **Direction change:** switching 1→0 starts debouncing from the current `pin_o`. Because `pin_o` already tracked `sync`, there is no spurious edge. Switching 0→1 mid-count aborts the count silently.
- **Pending flags:**
  - Set: `rise_o[i] & rise_en_i[i]` or `fall_o[i] & fall_en_i[i]` sets `pending_o[i]`.
  - Clear: `irq_clr_i[i]` clears it.
  - Set and clear in the same cycle: set wins, and the flag stays 1.
- **Interrupt:** `irq_o` = |`pending_o`. It is driven combinationally from the pending register.
- Pins are fully independent. Edges on several pins in the same cycle set all corresponding flags.

## Timing
- **Reset values:** all outputs 0, plus both sync stages, `cnt`, and pending. Reset is asserted asynchronously and takes effect mid-count. Any count in progress is discarded.
- **Latency, input pin:** a pad step stable from cycle T (sampled at edge T) gives `pin_o` and the edge pulse at edge T+1+DEBOUNCE_CYCLES. That is 2 sync cycles plus DEBOUNCE_CYCLES−1 count cycles.
- **Latency, output pin:** `pin_o` follows the pad with 2 cycles latency.
- **Edge pulses and pending:**
  - `rise_o` and `fall_o` are registered and change on the same edge as `pin_o`.
  - `pending_o` sets one edge later.
  - `irq_o` follows `pending_o` in the same cycle.
- **Throughput:** the minimum spacing between accepted transitions on one pin is DEBOUNCE_CYCLES cycles.

## Configuration
- Macro: `GPIO_IN_FILTER_IRQ_EN`.
- **Defined:** pending flags and `irq_o` are implemented as above.
- **Undefined:**
  - No pending registers exist.
  - `pending_o` and `irq_o` are tied to 0.
  - `rise_en_i`, `fall_en_i` and `irq_clr_i` are ignored.
  - `pin_o`, `rise_o` and `fall_o` behave identically to the defined case.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and GPIO_NUM=8.
- **Clean rise:** `pad_i[0]` goes 0→1 at edge 10 and is held, with `rise_en_i[0]=1` → `pin_o[0]=1` and `rise_o[0]` pulses at edge 15; `pending_o[0]=1` and `irq_o=1` at edge 16.
- **Glitch rejection:** `pad_i[1]` is high for 3 cycles, then returns low → `pin_o[1]` stays 0; `rise_o`, `fall_o` and `pending_o` stay 0.
- **Set/clear collision:** `pending_o[2]=1`, then `irq_clr_i[2]` is pulsed in the same cycle a new enabled fall on pin 2 is detected → `pending_o[2]` remains 1; a later lone clear drops it to 0 and `irq_o=0`.
- **Output pin:** with `dir_i[3]=1`, `pad_i[3]` toggles every 2 cycles → `pin_o[3]` follows with 2-cycle lag and no edge pulses. After switching `dir_i[3]=0` with the pad held high, there are no pulses.
- **Simultaneous pins:** pins 4 and 5 rise at the same cycle with `rise_en_i=8'h30` → both `rise_o` bits pulse on the same edge and `pending_o=8'h30`.
- **Reset mid-count:** `pad_i[6]` is high for 2 debounce cycles, then `resetn` is pulsed low for 1 cycle → all outputs are 0 immediately, and `pin_o[6]` rises 6 cycles after reset release.
